uart_rx_flow: RTL and testbench

// - Parametrised UART receiver: configurable frame format, 3-sample majority filtering,

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_rx_flow.sv | 156 +++++++++++++++
 tb/tb_uart_rx_flow.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the flow-controlled UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

  function automatic logic vote3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; a push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign pop_valid = (level != '0);
  assign full      = (level == LW'(DEPTH));
  assign do_pop    = pop_valid && pop_ready;
  assign do_push   = push && (!full || do_pop);
  assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; the output mux hides stale entries, so only pointers and level need one.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_flow.sv
// UART receiver with majority-vote sampling, parity/framing checks, receive FIFO and CTS hysteresis.
module uart_rx_flow
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ_HZ = 100_000_000,
  parameter int      BAUD_RATE   = 2_000_000,
  parameter int      DATA_BITS   = 8,
  parameter parity_e PARITY      = PAR_NONE,
  parameter int      STOP_BITS   = 1,
  parameter int      FIFO_DEPTH  = 16,
  parameter int      CTS_MARGIN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bit_in,
  output logic [DATA_BITS-1:0]          byte_out_data,
  output logic                          byte_out_valid,
  input  logic                          byte_out_ready,
  output logic                          cts_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int BW           = $clog2(DATA_BITS);
  localparam int LW           = $clog2(FIFO_DEPTH) + 1;

  always_ff @(posedge clk) begin
    assert (CLKS_PER_BIT >= 8 && DATA_BITS >= 5 && DATA_BITS <= 9 &&
            (STOP_BITS == 1 || STOP_BITS == 2) && CTS_MARGIN < FIFO_DEPTH / 2)
      else $error("uart_rx_flow: unsupported configuration");
  end

  logic [1:0]           sync;
  logic [1:0]           hist;
  logic [1:0]           arm_cnt;
  logic                 armed;
  logic                 rx;
  logic                 vote;
  rx_state_e            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 tick;
  logic                 last_stop;
  logic                 push;
  logic                 pop;
  logic                 full;

  assign rx        = sync[1];
  assign vote      = vote3({hist, rx});
  assign tick      = (cnt == ((state == S_START) ? CW'(HALF) : CW'(CLKS_PER_BIT - 1)));
  assign last_stop = (bit_idx == BW'(STOP_BITS - 1));
  assign push      = (state == S_STOP) && tick && vote && last_stop && !par_bad;
  assign pop       = byte_out_valid && byte_out_ready;

  // The first two synchronised samples after reset are the reset value, not the line, so arming
  // waits for them to flush and then for a genuine idle-high sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      hist    <= 2'b11;
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      sync <= {sync[0], bit_in};
      hist <= {hist[0], rx};
      if (arm_cnt != 2'd2) arm_cnt <= arm_cnt + 2'd1;
      else if (rx)         armed   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      cnt        <= tick ? '0 : cnt + CW'(1);
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          par_bad <= 1'b0;
          if (armed && hist[0] && !rx) state <= S_START;
        end
        S_START: if (tick) state <= vote ? S_IDLE : S_DATA;
        S_DATA: if (tick) begin
          shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            bit_idx <= '0;
            state   <= (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
          end else begin
            bit_idx <= bit_idx + BW'(1);
          end
        end
        S_PARITY: if (tick) begin
          par_bad <= (^shreg) ^ vote ^ (PARITY == PAR_ODD);
          state   <= S_STOP;
        end
        S_STOP: if (tick) begin
          if (!vote) begin
            frame_err <= 1'b1;
            state     <= S_BREAK;
          end else if (last_stop) begin
            parity_err <= par_bad;
            state      <= S_IDLE;
          end else begin
            bit_idx <= bit_idx + BW'(1);
          end
        end
        S_BREAK: if (rx) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Framing and parity failures never push, so overflow is naturally the lowest-priority pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      cts_out  <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (fifo_level >= LW'(FIFO_DEPTH - CTS_MARGIN)) cts_out <= 1'b0;
      else if (fifo_level <= LW'(FIFO_DEPTH / 2))    cts_out <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .full      (full),
    .pop_data  (byte_out_data),
    .pop_valid (byte_out_valid),
    .pop_ready (byte_out_ready),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_uart_rx_flow.sv
// Scoreboard bench for uart_rx_flow: 8N1, 8E1 and 7-bit/2-stop fast instances share clock and reset.
module tb_uart_rx_flow;
  import uart_pkg::*;

  localparam int CPB_A = 50;
  localparam int CPB_C = 8;

  typedef enum logic [1:0] {EV_PARITY, EV_FRAME, EV_OVERFLOW} ev_e;
  typedef struct { int inst; logic [8:0] data; } data_exp_t;
  typedef struct { int inst; ev_e kind; } err_exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] line;
  logic [2:0] ready;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         t0;

  logic       v0, v1, v2, c0, c1, c2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [4:0] lv0, lv1, lv2;
  logic [2:0] valid_v, cts_v, pe_v, fe_v, ov_v;
  logic [8:0] dout [3];

  data_exp_t data_q[$];
  err_exp_t  err_q[$];

  assign valid_v = {v2, v1, v0};
  assign cts_v   = {c2, c1, c0};
  assign pe_v    = {pe2, pe1, pe0};
  assign fe_v    = {fe2, fe1, fe0};
  assign ov_v    = {ov2, ov1, ov0};
  assign dout[0] = {1'b0, d0};
  assign dout[1] = {1'b0, d1};
  assign dout[2] = {2'b00, d2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_flow dut_a (
    .clk(clk), .rst_n(rst_n), .bit_in(line[0]),
    .byte_out_data(d0), .byte_out_valid(v0), .byte_out_ready(ready[0]),
    .cts_out(c0), .fifo_level(lv0), .parity_err(pe0), .frame_err(fe0), .overflow(ov0)
  );

  uart_rx_flow #(.PARITY(PAR_EVEN)) dut_b (
    .clk(clk), .rst_n(rst_n), .bit_in(line[1]),
    .byte_out_data(d1), .byte_out_valid(v1), .byte_out_ready(ready[1]),
    .cts_out(c1), .fifo_level(lv1), .parity_err(pe1), .frame_err(fe1), .overflow(ov1)
  );

  uart_rx_flow #(.BAUD_RATE(12_500_000), .DATA_BITS(7), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .bit_in(line[2]),
    .byte_out_data(d2), .byte_out_valid(v2), .byte_out_ready(ready[2]),
    .cts_out(c2), .fifo_level(lv2), .parity_err(pe2), .frame_err(fe2), .overflow(ov2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_byte(input int inst, input logic [8:0] d);
    data_exp_t e;
    e.inst = inst;
    e.data = d;
    data_q.push_back(e);
  endtask

  task automatic exp_err(input int inst, input ev_e k);
    err_exp_t e;
    e.inst = inst;
    e.kind = k;
    err_q.push_back(e);
  endtask

  task automatic take_byte(input int i);
    data_exp_t e;
    check($sformatf("byte_expected_dut%0d", i), 32'(data_q.size() != 0), 32'd1);
    if (data_q.size() != 0) begin
      e = data_q.pop_front();
      check($sformatf("byte_dut%0d", i), (i << 12) | 32'(dout[i]), (e.inst << 12) | 32'(e.data));
    end
  endtask

  task automatic take_err(input int i, input ev_e k);
    err_exp_t e;
    check($sformatf("err_expected_dut%0d_kind%0d", i, k), 32'(err_q.size() != 0), 32'd1);
    if (err_q.size() != 0) begin
      e = err_q.pop_front();
      check($sformatf("err_dut%0d", i), (i << 4) | 32'(k), (e.inst << 4) | 32'(e.kind));
    end
  endtask

  // Monitor: every transfer or error pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (valid_v[i] && ready[i]) take_byte(i);
        if (pe_v[i]) take_err(i, EV_PARITY);
        if (fe_v[i]) take_err(i, EV_FRAME);
        if (ov_v[i]) take_err(i, EV_OVERFLOW);
      end
    end
  end

  task automatic drive_bits(input int inst, input logic v, input int cycles);
    line[inst] = v;
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input int inst, input logic [8:0] data, input int nbits, input int cpb,
                            input logic has_par, input logic par, input logic [1:0] stops,
                            input int nstop);
    drive_bits(inst, 1'b0, cpb);
    for (int b = 0; b < nbits; b++) drive_bits(inst, data[b], cpb);
    if (has_par) drive_bits(inst, par, cpb);
    for (int s = 0; s < nstop; s++) drive_bits(inst, stops[s], cpb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    line  = 3'b111;
    ready = 3'b111;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 32'(valid_v), 32'd0);
    check("rst_cts", 32'(cts_v), 32'd0);
    check("rst_level", {lv2, lv1, lv0}, 32'd0);
    check("rst_data", {d2, d1, d0}, 32'd0);
    check("rst_err_pulses", {pe_v, fe_v, ov_v}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("cts_before_first_edge", 32'(cts_v), 32'd0);
    @(negedge clk);
    check("cts_one_clk_after_reset", 32'(cts_v), 32'b111);
    @(posedge clk);
    #2;

    // 0xA5 8N1: stop sampled 479 edges after the start bit is driven
    exp_byte(0, 9'h0A5);
    t0 = cyc;
    fork
      send_frame(0, 9'h0A5, 8, CPB_A, 1'b0, 1'b0, 2'b11, 1);
      begin
        while (cyc < t0 + 478) @(negedge clk);
        check("a5_valid_before_stop_sample", 32'(v0), 32'd0);
        @(negedge clk);
        check("a5_valid_after_stop_sample", 32'(v0), 32'd1);
      end
    join
    drive_bits(0, 1'b1, CPB_A);

    // Stop bit low, line held low: one frame error, then recovery
    exp_err(0, EV_FRAME);
    send_frame(0, 9'h0F0, 8, CPB_A, 1'b0, 1'b0, 2'b00, 1);
    drive_bits(0, 1'b0, 20 * CPB_A);
    drive_bits(0, 1'b1, 2 * CPB_A);
    exp_byte(0, 9'h055);
    send_frame(0, 9'h055, 8, CPB_A, 1'b0, 1'b0, 2'b11, 1);
    drive_bits(0, 1'b1, CPB_A);

    // Short low glitch on the idle line
    drive_bits(0, 1'b0, 20);
    drive_bits(0, 1'b1, 4 * CPB_A);
    check("glitch_level", 32'(lv0), 32'd0);

    // Flow control: fill with ready low, overflow, then drain
    ready[0] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_byte(0, 9'(k));
      send_frame(0, 9'(k), 8, CPB_A, 1'b0, 1'b0, 2'b11, 1);
      check($sformatf("fill_level_%0d", k + 1), 32'(lv0), 32'(k + 1));
      check($sformatf("fill_cts_%0d", k + 1), 32'(c0), 32'(k + 1 < 12));
    end
    check("head_valid_held", 32'(v0), 32'd1);
    check("head_data_held", 32'(d0), 32'd0);
    exp_err(0, EV_OVERFLOW);
    send_frame(0, 9'h0AA, 8, CPB_A, 1'b0, 1'b0, 2'b11, 1);
    check("overflow_level", 32'(lv0), 32'd16);
    check("overflow_head", 32'(d0), 32'd0);
    for (int l = 15; l >= 0; l--) begin
      ready[0] = 1'b1;
      @(posedge clk);
      #2;
      ready[0] = 1'b0;
      @(posedge clk);
      #2;
      check($sformatf("drain_level_%0d", l), 32'(lv0), 32'(l));
      check($sformatf("drain_cts_%0d", l), 32'(c0), 32'(l <= 8));
    end
    ready[0] = 1'b1;

    // Reset during data bit 4 of an all-zero frame
    fork
      send_frame(0, 9'h000, 8, CPB_A, 1'b0, 1'b0, 2'b11, 1);
      begin
        repeat (5 * CPB_A + 25) begin
          @(posedge clk);
          #2;
        end
        rst_n = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #2;
        end
        rst_n = 1'b1;
      end
    join
    drive_bits(0, 1'b1, 2 * CPB_A);
    check("mid_reset_level", 32'(lv0), 32'd0);
    exp_byte(0, 9'h03C);
    send_frame(0, 9'h03C, 8, CPB_A, 1'b0, 1'b0, 2'b11, 1);
    drive_bits(0, 1'b1, CPB_A);

    // Even parity instance
    exp_err(1, EV_PARITY);
    send_frame(1, 9'h003, 8, CPB_A, 1'b1, 1'b1, 2'b11, 1);
    drive_bits(1, 1'b1, CPB_A);
    exp_byte(1, 9'h003);
    send_frame(1, 9'h003, 8, CPB_A, 1'b1, 1'b0, 2'b11, 1);
    exp_byte(1, 9'h007);
    send_frame(1, 9'h007, 8, CPB_A, 1'b1, 1'b1, 2'b11, 1);
    drive_bits(1, 1'b1, CPB_A);

    // 7 data bits, 2 stop bits, 8 clk/bit
    exp_byte(2, 9'h07F);
    exp_byte(2, 9'h000);
    send_frame(2, 9'h07F, 7, CPB_C, 1'b0, 1'b0, 2'b11, 2);
    send_frame(2, 9'h000, 7, CPB_C, 1'b0, 1'b0, 2'b11, 2);
    drive_bits(2, 1'b1, 2 * CPB_C);
    exp_err(2, EV_FRAME);
    send_frame(2, 9'h055, 7, CPB_C, 1'b0, 1'b0, 2'b01, 2);
    drive_bits(2, 1'b1, 4 * CPB_C);
    exp_byte(2, 9'h02A);
    send_frame(2, 9'h02A, 7, CPB_C, 1'b0, 1'b0, 2'b11, 2);
    drive_bits(2, 1'b1, 4 * CPB_C);

    check("data_queue_empty", 32'(data_q.size()), 32'd0);
    check("err_queue_empty", 32'(err_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
